uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter (baud-rate generator plus TX serializer) among several word-wide requesters in the MIPS debug path, such as the register-file dump, PC/status report and memory dump.
- Arbitrates round-robin among the requesters.
- Latches the granted word and splits it into NB_DATA-bit bytes, least-significant byte first.
- Sequences each byte into the transmitter with a start pulse and waits for the transmitter's done tick.
- Acknowledges the requester when its whole word has been sent.
- Aborts with an error pulse if the transmitter stalls.

---
 rtl/uart_sched_pkg.sv | 22 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
// The scheduler and its round-robin arbiter both import this package.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    ABORT = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int nb_word, input int nb_data);
    return nb_word / nb_data;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly after
// last_grant, wrapping around, so the previous winner is considered last.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [cnt_width(N_REQ)-1:0] last_grant,
  output logic [cnt_width(N_REQ)-1:0] grant_idx,
  output logic                        any_req
);

  localparam int GW = cnt_width(N_REQ);

  int idx_s;

  // Scan from the farthest candidate down so the nearest one is written last.
  always_comb begin
    grant_idx = GW'(0);
    idx_s     = 0;
    any_req   = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      idx_s     = (int'(last_grant) + i) % N_REQ;
      grant_idx = req[idx_s] ? GW'(idx_s) : grant_idx;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ word-wide requesters: round-robin
// grant, LSB-first byte sequencing, per-byte timeout with error pulse.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 200000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*NB_WORD-1:0]    word_in,
  output logic [N_REQ-1:0]            ack,
  output logic                        err,
  output logic                        tx_start,
  output logic [NB_DATA-1:0]          tx_din,
  input  logic                        tx_done_tick,
  output logic                        busy,
  output logic [cnt_width(N_REQ)-1:0] grant_id
);

  localparam int BYTES = bytes_per_word(NB_WORD, NB_DATA);
  localparam int GW    = cnt_width(N_REQ);
  localparam int BCW   = cnt_width(BYTES);
  localparam int TCW   = cnt_width(TIMEOUT);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic [NB_WORD-1:0] shift_r;
  logic [BCW-1:0]     byte_cnt_r;
  logic [TCW-1:0]     to_cnt_r;
  logic [GW-1:0]      grant_r;
  logic [GW-1:0]      last_grant_r;
  logic [GW-1:0]      grant_s;
  logic               any_req_s;
  logic [N_REQ-1:0]   ack_r;
  logic               err_r;
  logic               tx_start_r;
  logic               busy_r;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_r),
    .grant_idx  (grant_s),
    .any_req    (any_req_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a tick takes priority over a timeout on the same cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_next_s = SEND;
        else           state_next_s = IDLE;
      end
      SEND: state_next_s = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (byte_cnt_r == LAST_BYTE) state_next_s = ACK;
          else                         state_next_s = SEND;
        end else if (to_cnt_r == TO_LAST) begin
          state_next_s = ABORT;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACK:     state_next_s = IDLE;
      ABORT:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Grant capture, word latch, byte shifting and timeout counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_r      <= {NB_WORD{1'b0}};
      byte_cnt_r   <= BCW'(0);
      to_cnt_r     <= TCW'(0);
      grant_r      <= GW'(0);
      last_grant_r <= GW'(N_REQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r    <= grant_s;
            shift_r    <= word_in[int'(grant_s)*NB_WORD +: NB_WORD];
            byte_cnt_r <= BCW'(0);
          end
        end
        SEND: to_cnt_r <= TCW'(0);
        WAIT: begin
          to_cnt_r <= to_cnt_r + TCW'(1);
          if (tx_done_tick && (byte_cnt_r != LAST_BYTE)) begin
            shift_r    <= shift_r >> NB_DATA;
            byte_cnt_r <= byte_cnt_r + BCW'(1);
          end
        end
        ACK:     last_grant_r <= grant_r;
        ABORT:   last_grant_r <= grant_r;
        default: ;
      endcase
    end
  end

  // Outputs registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_r      <= {N_REQ{1'b0}};
      err_r      <= 1'b0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      ack_r      <= (state_next_s == ACK) ? (N_REQ'(1'b1) << grant_r) : {N_REQ{1'b0}};
      err_r      <= (state_next_s == ABORT);
      tx_start_r <= (state_next_s == SEND);
      busy_r     <= (state_next_s != IDLE);
    end
  end

  assign ack      = ack_r;
  assign err      = err_r;
  assign tx_start = tx_start_r;
  assign tx_din   = shift_r[NB_DATA-1:0];
  assign busy     = busy_r;
  assign grant_id = grant_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected bytes, acks
// and errors; a negedge monitor pops and compares whenever the DUT emits one.
module tb_uart_tx_scheduler;

  localparam int TO = 50;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [95:0] word_in;
  logic [2:0]  ack;
  logic        err;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic        busy;
  logic [1:0]  grant_id;

  logic model_tick, spur_tick, auto_resp;
  assign tx_done_tick = model_tick | spur_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = -100;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } exp_t;

  exp_t       exp_byte[$];
  logic [2:0] exp_ack[$];
  logic [1:0] exp_err[$];

  uart_tx_scheduler #(
    .NB_DATA (8),
    .NB_WORD (32),
    .N_REQ   (3),
    .TIMEOUT (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .word_in      (word_in),
    .ack          (ack),
    .err          (err),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty expectation queue", name);
  endtask

  task automatic push_bytes(input logic [31:0] w, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = w[8*i +: 8];
      e.first = (i == 0);
      exp_byte.push_back(e);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    word_in[32*i +: 32] = w;
  endtask

  // kind 0: tx_start, 1: ack, 2: err. Returns the monitor cycle number.
  task automatic wait_evt(input string name, input int kind, output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      #1;
      if ((kind == 0 && tx_start) || (kind == 1 && ack != 3'b000) || (kind == 2 && err)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within 400 cycles", name);
    end
  endtask

  // Transmitter model: done tick three cycles after the start pulse.
  initial begin
    model_tick = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_start && auto_resp && !reset) begin
        repeat (3) @(posedge clock);
        #1 model_tick = 1'b1;
        @(posedge clock);
        #1 model_tick = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT output event.
  initial begin
    exp_t e;
    logic [2:0] a;
    logic [1:0] g;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (tx_start) begin
          if (exp_byte.size() == 0) fail_evt("tx_start");
          else begin
            e = exp_byte.pop_front();
            check("tx_din", {24'h0, tx_din}, {24'h0, e.b});
            if (!e.first) check("start_after_tick", cyc - last_tick, 1);
          end
        end
        if (ack != 3'b000) begin
          if (exp_ack.size() == 0) fail_evt("ack");
          else begin
            a = exp_ack.pop_front();
            check("ack_vec", {29'h0, ack}, {29'h0, a});
            check("ack_after_tick", cyc - last_tick, 1);
          end
        end
        if (err) begin
          if (exp_err.size() == 0) fail_evt("err");
          else begin
            g = exp_err.pop_front();
            check("err_grant", {30'h0, grant_id}, {30'h0, g});
            check("err_no_ack", {29'h0, ack}, 32'h0);
          end
        end
      end
      if (model_tick) last_tick = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, started, idle, nack;
    reset = 1'b1;
    req = 3'b000;
    word_in = 96'h0;
    spur_tick = 1'b0;
    auto_resp = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ack", {29'h0, ack}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_din", {24'h0, tx_din}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_grant_id", {30'h0, grant_id}, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Single request, plus request-to-start latency.
    set_word(0, 32'h11223344);
    push_bytes(32'h11223344, 4);
    exp_ack.push_back(3'b001);
    @(posedge clock);
    #1 req = 3'b001;
    @(negedge clock);
    #1 t0 = cyc;
    check("idle_busy", {31'h0, busy}, 32'h0);
    wait_evt("single_start", 0, t1);
    check("req_to_start", t1 - t0, 1);
    check("single_grant", {30'h0, grant_id}, 32'h0);
    wait_evt("single_ack", 1, t1);
    @(posedge clock);
    #1 req = 3'b000;

    // Round robin from reset with all three requesting.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    set_word(0, 32'h03020100);
    set_word(1, 32'h13121110);
    set_word(2, 32'h23222120);
    push_bytes(32'h03020100, 4); exp_ack.push_back(3'b001);
    push_bytes(32'h13121110, 4); exp_ack.push_back(3'b010);
    push_bytes(32'h23222120, 4); exp_ack.push_back(3'b100);
    push_bytes(32'h03020100, 4); exp_ack.push_back(3'b001);
    req = 3'b111;
    started = 0; idle = 0; nack = 0;
    for (int n = 0; n < 400 && nack < 4; n++) begin
      @(negedge clock);
      #1;
      if (tx_start) started = 1;
      if (started != 0 && !busy) idle++;
      if (ack != 3'b000) nack++;
    end
    check("rr_acks", nack, 4);
    check("rr_idle_gaps", idle, 3);
    @(posedge clock);
    #1 req = 3'b000;

    // Word latched at grant: change word and drop req during byte 1.
    set_word(1, 32'hAABBCCDD);
    push_bytes(32'hAABBCCDD, 4);
    exp_ack.push_back(3'b010);
    @(posedge clock);
    #1 req = 3'b010;
    wait_evt("latch_b0", 0, t1);
    wait_evt("latch_b1", 0, t1);
    @(posedge clock);
    #1 set_word(1, 32'h55667788);
    req = 3'b000;
    wait_evt("latch_ack", 1, t1);

    // Spurious ticks while IDLE and during SEND.
    set_word(0, 32'hCAFEF00D);
    push_bytes(32'hCAFEF00D, 4);
    exp_ack.push_back(3'b001);
    @(posedge clock);
    #1 req = 3'b001;
    spur_tick = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 spur_tick = 1'b0;
    wait_evt("spur_ack", 1, t1);
    @(posedge clock);
    #1 req = 3'b000;

    // Timeout on requester 1, then requester 2 is served.
    set_word(1, 32'h01020304);
    set_word(2, 32'h0A0B0C0D);
    push_bytes(32'h01020304, 1);
    exp_err.push_back(2'd1);
    push_bytes(32'h0A0B0C0D, 4);
    exp_ack.push_back(3'b100);
    @(posedge clock);
    #1 auto_resp = 1'b0;
    req = 3'b110;
    wait_evt("to_start", 0, t0);
    wait_evt("to_err", 2, t1);
    check("timeout_latency", t1 - t0, TO + 1);
    @(posedge clock);
    #1 req = 3'b100;
    auto_resp = 1'b1;
    wait_evt("after_to_ack", 1, t1);
    @(posedge clock);
    #1 req = 3'b000;

    // Asynchronous reset during byte 2 drops the word silently.
    set_word(0, 32'h99887766);
    push_bytes(32'h99887766, 2);
    @(posedge clock);
    #1 req = 3'b001;
    wait_evt("mid_b0", 0, t1);
    wait_evt("mid_b1", 0, t1);
    check("mid_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_tx_start", {31'h0, tx_start}, 32'h0);
    check("mid_busy_rst", {31'h0, busy}, 32'h0);
    check("mid_tx_din", {24'h0, tx_din}, 32'h0);
    check("mid_grant_id", {30'h0, grant_id}, 32'h0);
    check("mid_ack", {29'h0, ack}, 32'h0);
    req = 3'b000;
    repeat (8) @(posedge clock);
    #1 reset = 1'b0;
    check("mid_queue_empty", exp_byte.size(), 0);
    set_word(1, 32'h44434241);
    set_word(2, 32'h54535251);
    push_bytes(32'h44434241, 4); exp_ack.push_back(3'b010);
    push_bytes(32'h54535251, 4); exp_ack.push_back(3'b100);
    req = 3'b110;
    wait_evt("post_ack1", 1, t1);
    @(posedge clock);
    #1 req = 3'b100;
    wait_evt("post_ack2", 1, t1);
    @(posedge clock);
    #1 req = 3'b000;

    repeat (5) @(posedge clock);
    #1;
    check("final_busy", {31'h0, busy}, 32'h0);
    check("final_bytes_left", exp_byte.size(), 0);
    check("final_acks_left", exp_ack.size(), 0);
    check("final_errs_left", exp_err.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
